// File: rtl/secuenciador_contador.sv
// Sweeps the per-FIFO pop counter (idx 0..3) while the switch is idle and
// publishes a consistent snapshot of the four counts plus their sum.
module secuenciador_contador #(
  parameter int CW      = 5,
  parameter int TW      = 7,
  parameter int TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          IDLE,
  input  logic          valid_contador,
  input  logic [CW-1:0] contador_out,
  output logic [1:0]    idx,
  output logic          req,
  output logic [CW-1:0] cnt_F0,
  output logic [CW-1:0] cnt_F1,
  output logic [CW-1:0] cnt_F2,
  output logic [CW-1:0] cnt_F3,
  output logic [TW-1:0] total,
  output logic          done,
  output logic          error,
  output logic          busy
);

  localparam int TMR_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {INICIO, PEDIR, ESPERAR, HECHO} state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [CW-1:0]    stg0, stg1, stg2;

  function automatic logic [TW-1:0] sum4(input logic [CW-1:0] a, input logic [CW-1:0] b,
                                         input logic [CW-1:0] c, input logic [CW-1:0] d);
    return TW'(a) + TW'(b) + TW'(c) + TW'(d);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= INICIO;
      idx    <= 2'd0;
      req    <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      busy   <= 1'b0;
      timer  <= '0;
      stg0   <= '0;
      stg1   <= '0;
      stg2   <= '0;
      cnt_F0 <= '0;
      cnt_F1 <= '0;
      cnt_F2 <= '0;
      cnt_F3 <= '0;
      total  <= '0;
    end else begin
      case (state)
        INICIO: begin
          if (start && IDLE) begin
            idx   <= 2'd0;
            error <= 1'b0;
            req   <= 1'b1;
            busy  <= 1'b1;
            state <= PEDIR;
          end
        end
        PEDIR: begin
          req   <= 1'b0;
          timer <= '0;
          state <= ESPERAR;
        end
        ESPERAR: begin
          if (!IDLE) begin
            busy  <= 1'b0;
            state <= INICIO;
          end else if (valid_contador) begin
            case (idx)
              2'd0: stg0 <= contador_out;
              2'd1: stg1 <= contador_out;
              2'd2: stg2 <= contador_out;
              default: begin
                // Publish on entry to HECHO so done coincides with fresh outputs
                cnt_F0 <= stg0;
                cnt_F1 <= stg1;
                cnt_F2 <= stg2;
                cnt_F3 <= contador_out;
                total  <= sum4(stg0, stg1, stg2, contador_out);
              end
            endcase
            if (idx == 2'd3) begin
              done  <= 1'b1;
              state <= HECHO;
            end else begin
              idx   <= idx + 2'd1;
              req   <= 1'b1;
              state <= PEDIR;
            end
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= INICIO;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        HECHO: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= INICIO;
        end
        default: state <= INICIO;
      endcase
    end
  end

endmodule

// File: tb/tb_secuenciador_contador.sv
// Randomized bench for secuenciador_contador with a responding counter model
// and a transaction-level timing/snapshot reference.
module tb_secuenciador_contador;

  localparam int CW      = 5;
  localparam int TW      = 7;
  localparam int TIMEOUT = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic          IDLE;
  logic          valid_contador;
  logic [CW-1:0] contador_out;
  logic [1:0]    idx;
  logic          req;
  logic [CW-1:0] cnt_F0, cnt_F1, cnt_F2, cnt_F3;
  logic [TW-1:0] total;
  logic          done;
  logic          error;
  logic          busy;

  secuenciador_contador #(.CW(CW), .TW(TW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .IDLE(IDLE),
    .valid_contador(valid_contador), .contador_out(contador_out),
    .idx(idx), .req(req),
    .cnt_F0(cnt_F0), .cnt_F1(cnt_F1), .cnt_F2(cnt_F2), .cnt_F3(cnt_F3),
    .total(total), .done(done), .error(error), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [CW-1:0] vals [4];
  int            exp_cnt [4];
  int            mute_idx = -1;
  int            drop_idx = -1;
  logic          stray_req = 1'b0;
  logic          stray_idle = 1'b0;
  logic          pend = 1'b0;
  logic [CW-1:0] pend_data = '0;
  logic          err_prev = 1'b0;

  int req_cyc[$];
  int req_idx[$];
  int done_cyc[$];
  int err_cyc = -1;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock, log DUT events, then let the counter model respond.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (req) begin
      req_cyc.push_back(cyc);
      req_idx.push_back(int'(idx));
      if (drop_idx >= 0 && int'(idx) == drop_idx) IDLE = 1'b0;
    end
    if (done) done_cyc.push_back(cyc);
    if (error && !err_prev) err_cyc = cyc;
    err_prev = error;
    valid_contador = pend | (stray_req & req) | stray_idle;
    contador_out   = pend ? pend_data : CW'($urandom);
    pend           = req && (int'(idx) != mute_idx);
    pend_data      = vals[idx];
  endtask

  task automatic check_snapshot(input string tag);
    check_val({tag, "_cnt0"}, int'(cnt_F0), exp_cnt[0]);
    check_val({tag, "_cnt1"}, int'(cnt_F1), exp_cnt[1]);
    check_val({tag, "_cnt2"}, int'(cnt_F2), exp_cnt[2]);
    check_val({tag, "_cnt3"}, int'(cnt_F3), exp_cnt[3]);
    check_val({tag, "_total"}, int'(total),
              exp_cnt[0] + exp_cnt[1] + exp_cnt[2] + exp_cnt[3]);
  endtask

  task automatic run(input int nsw, input int win);
    int  k, stop, nexp, ne, n0;
    bit  term;
    req_cyc.delete();
    req_idx.delete();
    done_cyc.delete();
    err_cyc = -1;
    start = 1'b1;
    IDLE  = 1'b1;
    cycle();
    k = cyc;
    check_val("err_clr", int'(error), 0);
    if (nsw == 1) start = 1'b0;
    for (int t = 0; t < win; t++) begin
      cycle();
      n0 = 0;
      foreach (req_idx[i]) if (req_idx[i] == 0) n0++;
      if (n0 >= nsw) start = 1'b0;
    end
    term = (mute_idx >= 0) || (drop_idx >= 0);
    stop = (mute_idx >= 0) ? mute_idx : (drop_idx >= 0) ? drop_idx : 3;
    nexp = term ? stop + 1 : 4 * nsw;
    check_val("req_count", req_cyc.size(), nexp);
    for (int i = 0; i < nexp && i < req_cyc.size(); i++) begin
      check_val("req_cyc", req_cyc[i] - k, (i / 4) * 10 + 2 * (i % 4));
      check_val("req_idx", req_idx[i], i % 4);
    end
    ne = term ? 0 : nsw;
    check_val("done_count", done_cyc.size(), ne);
    for (int i = 0; i < ne && i < done_cyc.size(); i++)
      check_val("done_cyc", done_cyc[i] - k, 10 * i + 8);
    if (!term) for (int j = 0; j < 4; j++) exp_cnt[j] = int'(vals[j]);
    check_snapshot("snap");
    check_val("error", int'(error), (mute_idx >= 0) ? 1 : 0);
    if (mute_idx >= 0) check_val("err_cyc", err_cyc - k, 2 * mute_idx + 1 + TIMEOUT);
    check_val("busy_end", int'(busy), 0);
    check_val("req_end", int'(req), 0);
  endtask

  task automatic rand_vals();
    for (int j = 0; j < 4; j++) vals[j] = CW'($urandom_range(0, (1 << CW) - 1));
  endtask

  initial begin
    int  mode;
    bit  seen;
    reset = 1'b1;
    start = 1'b1;
    IDLE = 1'b1;
    valid_contador = 1'b0;
    contador_out = '0;
    for (int j = 0; j < 4; j++) begin vals[j] = '0; exp_cnt[j] = 0; end
    cycle();
    cycle();
    check_val("rst_idx", int'(idx), 0);
    check_val("rst_req", int'(req), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_error", int'(error), 0);
    check_val("rst_busy", int'(busy), 0);
    check_snapshot("rst");
    reset = 1'b0;
    start = 1'b0;
    cycle();

    vals[0] = 5'd3; vals[1] = 5'd0; vals[2] = 5'd31; vals[3] = 5'd7;
    run(1, 30);
    check_val("total_41", int'(total), 41);

    for (int j = 0; j < 4; j++) vals[j] = 5'd31;
    run(1, 30);
    check_val("total_124", int'(total), 124);

    rand_vals();
    drop_idx = 2;
    run(1, 30);
    drop_idx = -1;
    start = 1'b1;
    for (int t = 0; t < 6; t++) cycle();
    check_val("idle_block", req_cyc.size(), 3);
    start = 1'b0;

    rand_vals();
    mute_idx = 1;
    run(1, 30);
    mute_idx = -1;
    rand_vals();
    run(1, 30);

    rand_vals();
    start = 1'b1;
    IDLE = 1'b1;
    cycle();
    start = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      cycle();
      if (req && idx == 2'd1) seen = 1'b1;
    end
    check_val("rst_mid_seen", int'(seen), 1);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int j = 0; j < 4; j++) exp_cnt[j] = 0;
    check_val("rstm_idx", int'(idx), 0);
    check_val("rstm_req", int'(req), 0);
    check_val("rstm_done", int'(done), 0);
    check_val("rstm_busy", int'(busy), 0);
    check_snapshot("rstm");
    rand_vals();
    run(1, 30);

    done_cyc.delete();
    stray_idle = 1'b1;
    for (int t = 0; t < 4; t++) cycle();
    stray_idle = 1'b0;
    cycle();
    check_val("stray_idle_done", done_cyc.size(), 0);
    check_snapshot("stray_idle");

    stray_req = 1'b1;
    rand_vals();
    run(2, 30);
    stray_req = 1'b0;

    for (int r = 0; r < 10; r++) begin
      rand_vals();
      mode = int'($urandom_range(0, 4));
      stray_req = 1'($urandom_range(0, 1));
      if (mode == 2) mute_idx = int'($urandom_range(0, 3));
      if (mode == 3) drop_idx = int'($urandom_range(0, 3));
      run((mode == 4) ? 2 : 1, 30);
      mute_idx = -1;
      drop_idx = -1;
      stray_req = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
